// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand handshake in, registered results out.
// The master side issues operations; the slave side is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             unsig;
  logic             out_valid;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             compout;
  logic             overflow;
  logic             div_zero;

  modport master (
    output in_valid, a, b, op, unsig,
    input  in_ready, out_valid, result_lo, result_hi, compout, overflow, div_zero
  );

  modport slave (
    input  in_valid, a, b, op, unsig,
    output in_ready, out_valid, result_lo, result_hi, compout, overflow, div_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub, WIDTH-iteration shift-add multiply
// and restoring divide on operand magnitudes, with sign correction folded into the final step.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clock,
  input logic      reset_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, mag_b, acc_hi, acc_lo;
  logic             unsig_r, is_div;

  logic [WIDTH-1:0] sum_ab, diff_ab, sc_lo, abs_a, abs_b;
  logic             sc_ovf, in_lt, is_iter;

  // Results for ops that complete on the accept edge, plus magnitudes for mul/div.
  always_comb begin
    sum_ab  = bus.a + bus.b;
    diff_ab = bus.a - bus.b;
    sc_lo   = '0;
    sc_ovf  = 1'b0;
    case (bus.op)
      4'b0000: sc_lo = bus.a & bus.b;
      4'b0001: sc_lo = bus.a | bus.b;
      4'b0100: sc_lo = ~(bus.a | bus.b);
      4'b0101: sc_lo = bus.a ^ bus.b;
      4'b0010: begin
        sc_lo  = sum_ab;
        sc_ovf = !bus.unsig && (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (sum_ab[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0110: begin
        sc_lo  = diff_ab;
        sc_ovf = !bus.unsig && (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (diff_ab[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: ;
    endcase
    in_lt   = bus.unsig ? (bus.a < bus.b) : ($signed(bus.a) < $signed(bus.b));
    is_iter = (bus.op == 4'b1000) || (bus.op == 4'b1001);
    abs_a   = (!bus.unsig && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b   = (!bus.unsig && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_sub, nxt_hi, nxt_lo;
  logic             div_ge;

  // One iteration: acc_lo holds the multiplier (shifted out right) or the dividend/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    div_sub   = div_shift[WIDTH-1:0] - mag_b;
    if (is_div) begin
      nxt_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_lo, fin_hi;
  logic               neg_res, neg_rem, fin_lt, fin_ovf, fin_dz;

  // Final result from the last iteration's values so it can be shown in DONE.
  always_comb begin
    neg_res  = !unsig_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    neg_rem  = !unsig_r && a_r[WIDTH-1];
    prod     = {nxt_hi, nxt_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -nxt_lo : nxt_lo;
    rem_fix  = neg_rem ? -nxt_hi : nxt_hi;
    fin_lt   = unsig_r ? (a_r < b_r) : ($signed(a_r) < $signed(b_r));
    fin_lo   = '0;
    fin_hi   = '0;
    fin_ovf  = 1'b0;
    fin_dz   = 1'b0;
    if (is_div) begin
      if (b_r == '0) begin
        fin_lo = '1;
        fin_hi = a_r;
        fin_dz = 1'b1;
      end else if (!unsig_r && (a_r == MIN_VAL) && (b_r == '1)) begin
        fin_lo  = MIN_VAL;
        fin_ovf = 1'b1;
      end else begin
        fin_lo = quo_fix;
        fin_hi = rem_fix;
      end
    end else begin
      fin_lo  = prod_fix[WIDTH-1:0];
      fin_hi  = prod_fix[2*WIDTH-1:WIDTH];
      fin_ovf = unsig_r ? (fin_hi != '0) : (fin_hi != {WIDTH{fin_lo[WIDTH-1]}});
    end
  end

  // Control FSM; result outputs are only written on the edge that raises out_valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      a_r           <= '0;
      b_r           <= '0;
      mag_b         <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      unsig_r       <= 1'b0;
      is_div        <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result_lo <= '0;
      bus.result_hi <= '0;
      bus.compout   <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.div_zero  <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            unsig_r <= bus.unsig;
            is_div  <= bus.op[0];
            if (is_iter) begin
              state        <= BUSY;
              bus.in_ready <= 1'b0;
              cnt          <= '0;
              acc_hi       <= '0;
              acc_lo       <= abs_a;
              mag_b        <= abs_b;
            end else begin
              bus.out_valid <= 1'b1;
              bus.result_lo <= sc_lo;
              bus.result_hi <= '0;
              bus.compout   <= in_lt;
              bus.overflow  <= sc_ovf;
              bus.div_zero  <= 1'b0;
            end
          end
        end
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == CW'(WIDTH - 1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result_lo <= fin_lo;
            bus.result_hi <= fin_hi;
            bus.compout   <= fin_lt;
            bus.overflow  <= fin_ovf;
            bus.div_zero  <= fin_dz;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;
  localparam int W = 32;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_NOR = 4'b0100,
                         OP_XOR = 4'b0101, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_MUL = 4'b1000, OP_DIV = 4'b1001;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic u);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    bus.unsig    = u;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid; 0 means the budget expired.
  task automatic waitPulse(input int budget, output int cycles, output logic readyLow);
    cycles   = 0;
    readyLow = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (bus.in_ready !== 1'b0) readyLow = 1'b0;
      if (bus.out_valid === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                             input logic [2:0] flags);
    checkOutput({tag, "_lo"}, 64'(bus.result_lo), 64'(lo));
    checkOutput({tag, "_hi"}, 64'(bus.result_hi), 64'(hi));
    checkOutput({tag, "_cmp_ovf_dz"}, 64'({bus.compout, bus.overflow, bus.div_zero}), 64'(flags));
  endtask

  task automatic runSingle(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic u, input logic [W-1:0] lo,
                           input logic [2:0] flags);
    int cyc;
    logic rl;
    applyStimulus(o, x, y, u);
    waitPulse(3, cyc, rl);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'd1);
    checkResult(tag, lo, '0, flags);
  endtask

  task automatic runIter(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic u, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic [2:0] flags);
    int cyc;
    logic rl;
    applyStimulus(o, x, y, u);
    waitPulse(W + 10, cyc, rl);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    checkOutput({tag, "_ready_low"}, 64'(rl), 64'd1);
    checkResult(tag, lo, hi, flags);
  endtask

  initial begin
    int pulses;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    bus.unsig    = 1'b0;

    // Reset held against a pending request: reset must win.
    repeat (3) @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    @(negedge clock);
    checkOutput("reset_ready_valid", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    checkResult("reset", '0, '0, 3'b000);

    runSingle("add_sovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 3'b010);

    // Back-to-back: sub then xor accepted on consecutive edges.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op = OP_SUB; bus.a = 32'd3; bus.b = 32'd5; bus.unsig = 1'b1;
    @(posedge clock);
    #1;
    bus.op = OP_XOR; bus.a = 32'h0000F0F0; bus.b = 32'h0000FFFF; bus.unsig = 1'b0;
    @(negedge clock);
    checkOutput("b2b_sub_valid", 64'(bus.out_valid), 64'd1);
    checkResult("b2b_sub", 32'hFFFFFFFE, '0, 3'b100);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    checkOutput("b2b_xor_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("b2b_xor_lo", 64'(bus.result_lo), 64'h0F0F);
    @(negedge clock);
    checkOutput("b2b_gap_valid", 64'(bus.out_valid), 64'd0);

    runSingle("and", OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'h0F000F00, 3'b000);
    runSingle("or",  OP_OR,  32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'hFF0FFF0F, 3'b000);
    runSingle("nor", OP_NOR, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'h00F000F0, 3'b000);
    runSingle("sub_sovf", OP_SUB, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 3'b110);
    runSingle("add_uwrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 3'b000);

    applyStimulus(4'b1111, 32'd5, 32'd6, 1'b0);
    @(negedge clock);
    checkOutput("undef_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("undef_lo_hi", {bus.result_hi, bus.result_lo}, 64'd0);
    checkOutput("undef_ovf_dz", 64'({bus.overflow, bus.div_zero}), 64'd0);

    runIter("mul_s", OP_MUL, 32'hFFFFFFFD, 32'd7, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 3'b100);
    @(negedge clock);
    checkOutput("hold_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("hold_lo", 64'(bus.result_lo), 64'hFFFFFFEB);
    checkOutput("hold_ready", 64'(bus.in_ready), 64'd1);

    runIter("mul_uovf", OP_MUL, 32'h00010000, 32'h00010000, 1'b1, 32'h0, 32'h1, 3'b010);
    runIter("div_s", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 3'b100);
    runIter("div_u", OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 3'b000);
    runIter("div_zero", OP_DIV, 32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 3'b001);
    runIter("div_minneg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'h0, 3'b110);

    // Abort a divide with a one-cycle reset ten cycles in.
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("abort_ready_valid", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    checkOutput("abort_lo_hi", {bus.result_hi, bus.result_lo}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) pulses++;
    end
    checkOutput("abort_no_pulse", 64'(pulses), 64'd0);
    runSingle("post_abort_add", OP_ADD, 32'd2, 32'd3, 1'b0, 32'd5, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal range is 8 to 64.
REQ-002 Ports SHALL be as listed, in this order:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  0000 and, 0001 or, 0100 nor, 0101 xor, 0010 add, 0110 sub, 1000 mul, 1001 div.
- unsig  in  1  1 = unsigned operation, 0 = two's-complement signed.
- out_valid  out  1  one-cycle pulse, results valid.
- result_lo  out  WIDTH  logic/add/sub result, low product, or quotient.
- result_hi  out  WIDTH  high product or remainder; 0 for all other ops.
- compout  out  1  a<b, signed or unsigned per unsig.
- overflow  out  1  signed/unsigned overflow as defined in REQ-010..012.
- div_zero  out  1  divide by zero.
REQ-003 There SHALL be one clock domain; reset SHALL be synchronous and active-low.

Function
REQ-004 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; a, b, op and unsig SHALL be captured on that edge.
REQ-005 The FSM SHALL have three states:
- IDLE: in_ready=1.
- BUSY: iterative mul/div; in_ready=0.
- DONE: one cycle; in_ready=0; out_valid=1.
REQ-006 Single-cycle ops (logic, add, sub) SHALL stay in IDLE and register all outputs on the accept edge, giving out_valid=1 in the following cycle (latency 1); back-to-back accepts SHALL be supported.
REQ-007 mul/div SHALL take IDLE->BUSY on accept. BUSY SHALL run exactly WIDTH iterations: radix-2 shift-add for mul, restoring division for div. The last iteration moves BUSY->DONE, then DONE->IDLE. out_valid SHALL therefore rise WIDTH+1 cycles after the accept edge.
REQ-008 Signed mul/div SHALL operate on operand magnitudes and apply sign correction in DONE. The quotient SHALL truncate toward zero; the remainder SHALL take the sign of a.
REQ-009 compout SHALL be produced for every op, from the captured operands.
REQ-010 For add/sub with unsig=0, overflow SHALL be set on signed overflow:
- add: operand signs equal and result sign differs.
- sub: operand signs differ and result sign differs from a.
For add/sub with unsig=1, overflow SHALL be 0.
REQ-011 For mul, overflow SHALL be set when result_hi is not all copies of result_lo[WIDTH-1] (signed), or when result_hi != 0 (unsigned).
REQ-012 For signed div of MIN by -1: result_lo = MIN, result_hi = 0, overflow = 1.
REQ-013 For div with b=0: result_lo = all ones, result_hi = a, div_zero = 1, with the normal WIDTH+1 latency.
REQ-014 In all cases not listed in REQ-010..013, overflow and div_zero SHALL be 0.
REQ-015 Result outputs SHALL hold their values between out_valid pulses and change only on a pulse edge.
REQ-016 Undefined op codes SHALL be accepted as single-cycle ops: result_lo = 0, result_hi = 0, flags 0.
REQ-017 in_valid while in_ready=0 SHALL be ignored; the requester must hold the request until it is accepted.

Reset
REQ-018 With reset_n=0 on an edge, the block SHALL enter IDLE; in_ready=1 and all other outputs SHALL be 0 in the next cycle.
REQ-019 Reset SHALL dominate in_valid on the same edge.
REQ-020 Reset during BUSY or DONE SHALL abort the operation, with no out_valid pulse for it.

Verification (WIDTH=32)
REQ-021 add, unsig=0, a=0x7FFFFFFF, b=1 -> next cycle: out_valid=1, result_lo=0x80000000, overflow=1, compout=0.
REQ-022 Back-to-back requests: sub unsig=1 with a=3, b=5, then xor with a=0xF0F0, b=0xFFFF, on consecutive cycles -> consecutive pulses: result_lo=0xFFFFFFFE with overflow=0 and compout=1, then result_lo=0x0F0F.
REQ-023 mul, unsig=0, a=-3, b=7 -> out_valid exactly 33 cycles after accept; result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB, overflow=0; in_ready=0 throughout BUSY/DONE.
REQ-024 div, unsig=0, a=-7, b=2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF.
REQ-025 div with b=0 -> div_zero=1, result_lo=0xFFFFFFFF, result_hi=a. Separately, signed div of 0x80000000 by 0xFFFFFFFF -> overflow=1.
REQ-026 reset_n=0 for one cycle, 10 cycles into a div -> no out_valid for that div; in_ready=1 the next cycle; a new add completes with latency 1.
